// File: rtl/future_pkg.sv
// Shared widths, FSM state encoding and mux select masks for the FUTURE round controller.
package future_pkg;

    localparam int FUTURE_BLOCK_W = 64;
    localparam int FUTURE_ROUNDS  = 10;
    localparam int FUTURE_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } future_state_e;

    localparam logic [FUTURE_BLOCK_W-1:0] SEL_LOAD = '1;
    localparam logic [FUTURE_BLOCK_W-1:0] SEL_FEED = '0;

endpackage

// File: rtl/future_round_ctrl.sv
// Round controller and state register for the FUTURE cipher, driving mux2x1_64bit.
// Optional FUTURE_ABORT_EN adds an 'abort' input that synchronously returns the block to IDLE.
//
// state | meaning
// IDLE  | ready for plaintext; captures in_data into the load register
// LOAD  | mux selects the load register into the state register
// ROUND | mux feeds round function output back; counter walks 0..NUM_ROUNDS-1
// DONE  | ciphertext presented on out_data until out_ready
module future_round_ctrl
    import future_pkg::*;
#(
    parameter int DATA_W     = FUTURE_BLOCK_W,
    parameter int NUM_ROUNDS = FUTURE_ROUNDS,
    parameter int CNT_W      = FUTURE_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] mux_a,
    output logic [DATA_W-1:0] mux_b,
    output logic [DATA_W-1:0] mux_s,
    input  logic [DATA_W-1:0] mux_c,
    output logic [DATA_W-1:0] rf_in,
    input  logic [DATA_W-1:0] rf_out,
    output logic [CNT_W-1:0]  rf_round,
    output logic              rf_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef FUTURE_ABORT_EN
    ,
    input  logic              abort
`endif
);

    future_state_e     r_fsm;
    logic [DATA_W-1:0] r_load;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_last;
    logic              w_abort;

`ifdef FUTURE_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_last = (r_fsm == ST_ROUND) && (r_cnt == CNT_W'(NUM_ROUNDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm  <= ST_IDLE;
            r_load <= '0;
            r_data <= '0;
            r_cnt  <= '0;
        end else if (w_abort) begin
            r_fsm  <= ST_IDLE;
            r_load <= '0;
            r_data <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_load <= in_data;
                        r_fsm  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_data <= mux_c;
                    r_cnt  <= '0;
                    r_fsm  <= ST_ROUND;
                end
                ST_ROUND: begin
                    r_data <= mux_c;
                    if (w_last) begin
                        r_cnt <= '0;
                        r_fsm <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_fsm <= ST_IDLE;
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_fsm == ST_IDLE);
    assign out_valid = (r_fsm == ST_DONE);
    assign out_data  = r_data;
    assign mux_a     = r_load;
    assign mux_b     = rf_out;
    assign mux_s     = (r_fsm == ST_ROUND) ? DATA_W'(SEL_FEED) : DATA_W'(SEL_LOAD);
    assign rf_in     = r_data;
    assign rf_round  = r_cnt;
    assign rf_last   = w_last;

endmodule
